// File: rtl/tick_block_averager.sv
// Block averager: accumulates 2^LOG2_N tick-qualified samples, then presents the
// floored mean through a single-entry valid/ready output register.
module tick_block_averager #(
   parameter int DATA_W = 24,
   parameter int LOG2_N = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     tick_i,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic                     clear_i,
   output logic signed [DATA_W-1:0] avg_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     overrun_o,
   output logic [LOG2_N-1:0]        fill_o
);

   localparam int ACC_W = DATA_W + LOG2_N;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  sample_ext;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [LOG2_N-1:0]        fill_q, fill_d;
   logic signed [DATA_W-1:0] avg_q, avg_d;
   logic                     valid_q, valid_d;
   logic                     overrun_q, overrun_d;
   logic                     last_tick;

   assign sample_ext = {{LOG2_N{sample_i[DATA_W-1]}}, sample_i};
   assign acc_sum    = acc_q + sample_ext;
   // fill is all-ones exactly when the current sample is the Nth of the block
   assign last_tick  = tick_i && (&fill_q);

   always_comb begin
      acc_d     = acc_q;
      fill_d    = fill_q;
      avg_d     = avg_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (clear_i) begin
         acc_d     = '0;
         fill_d    = '0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         if (valid_q && ready_i) begin
            valid_d = 1'b0;
         end
         if (last_tick) begin
            // Dropping the low LOG2_N bits is an arithmetic shift: floor division by N
            avg_d   = acc_sum[ACC_W-1:LOG2_N];
            valid_d = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
            if (valid_q && !ready_i) begin
               overrun_d = 1'b1;
            end
         end else if (tick_i) begin
            acc_d  = acc_sum;
            fill_d = fill_q + LOG2_N'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         acc_q     <= '0;
         fill_q    <= '0;
         avg_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         fill_q    <= fill_d;
         avg_q     <= avg_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign avg_o     = avg_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;
   assign fill_o    = fill_q;

endmodule

// File: tb/tb_tick_block_averager.sv
// Randomized and directed bench for tick_block_averager against a queue-based
// reference model that averages each block with plain integer arithmetic.
module tb_tick_block_averager;

   localparam int DATA_W = 24;
   localparam int LOG2_N = 4;
   localparam int N      = 1 << LOG2_N;

   logic                     clk_i = 1'b0;
   logic                     reset_ni;
   logic                     tick_i;
   logic signed [DATA_W-1:0] sample_i;
   logic                     clear_i;
   logic signed [DATA_W-1:0] avg_o;
   logic                     valid_o;
   logic                     ready_i;
   logic                     overrun_o;
   logic [LOG2_N-1:0]        fill_o;

   tick_block_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .tick_i    (tick_i),
      .sample_i  (sample_i),
      .clear_i   (clear_i),
      .avg_o     (avg_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .overrun_o (overrun_o),
      .fill_o    (fill_o)
   );

   always #5 clk_i = ~clk_i;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     n_blocks = 0;

   // reference model state
   longint blk_q[$];
   longint m_avg = 0;
   bit     m_valid = 0;
   bit     m_over = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint floor_div(input longint num, input longint den);
      longint q;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".avg"},     longint'(avg_o), m_avg);
      check({tag, ".valid"},   longint'(valid_o), longint'(m_valid));
      check({tag, ".overrun"}, longint'(overrun_o), longint'(m_over));
      check({tag, ".fill"},    longint'(fill_o), longint'(blk_q.size()));
   endtask

   task automatic model_edge(input bit t, input longint s, input bit c, input bit r);
      longint sum;
      bit consumed;
      if (c) begin
         blk_q.delete();
         m_valid = 0;
         m_over  = 0;
         return;
      end
      consumed = m_valid && r;
      if (t) blk_q.push_back(s);
      if (blk_q.size() == N) begin
         sum = 0;
         foreach (blk_q[k]) sum += blk_q[k];
         m_avg = floor_div(sum, N);
         if (m_valid && !r) m_over = 1;
         m_valid = 1;
         blk_q.delete();
         n_blocks++;
         $display("[TB] block %0d complete: expected avg %0d", n_blocks, m_avg);
      end else if (consumed) begin
         m_valid = 0;
      end
   endtask

   // one clock cycle: drive, clock, update model, check 1 time unit after the edge
   task automatic cyc(input bit t, input longint s, input bit c, input bit r, input string tag);
      tick_i   = t;
      sample_i = DATA_W'(s);
      clear_i  = c;
      ready_i  = r;
      @(posedge clk_i);
      model_edge(t, s, c, r);
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input int cnt, input longint val, input int gap, input bit r, input string tag);
      for (int i = 0; i < cnt; i++) begin
         cyc(1'b1, val, 1'b0, r, tag);
         for (int g = 0; g < gap; g++) cyc(1'b0, 0, 1'b0, r, tag);
      end
   endtask

   task automatic do_reset_pulse(input string tag);
      #2;
      reset_ni = 1'b0;
      #1;
      blk_q.delete();
      m_avg = 0; m_valid = 0; m_over = 0;
      check_all(tag);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      check_all({tag, ".held"});
   endtask

   initial begin
      longint s;
      logic [DATA_W-1:0] r24;
      reset_ni = 1'b0;
      tick_i = 1'b0; sample_i = '0; clear_i = 1'b0; ready_i = 1'b0;
      #1;
      check_all("reset_async");
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check_all("reset_held");
      reset_ni = 1'b1;

      // slow ticks, always ready
      ticks(16, 100, 2, 1'b1, "slow100");
      cyc(1'b0, 0, 1'b0, 1'b1, "slow100.drain");

      // floor rounding
      ticks(15, 0, 0, 1'b1, "floor0");
      ticks(1, -1, 0, 1'b1, "floor_m1");
      check("floor.avg_m1", longint'(avg_o), -1);
      ticks(16, -3, 0, 1'b1, "neg3");

      // extremes back-to-back
      ticks(16, 8388607, 0, 1'b1, "maxpos");
      check("maxpos.avg", longint'(avg_o), 8388607);
      ticks(16, -8388608, 0, 1'b1, "maxneg");
      check("maxneg.avg", longint'(avg_o), -8388608);

      // stalled consumer, overrun
      ticks(32, 5, 0, 1'b0, "stall5");
      check("stall5.overrun", longint'(overrun_o), 1);
      ticks(32, 7, 0, 1'b0, "stall7");
      cyc(1'b0, 0, 1'b0, 1'b1, "stall.accept");
      cyc(1'b0, 0, 1'b0, 1'b1, "stall.sticky");
      cyc(1'b0, 0, 1'b1, 1'b0, "stall.clear");

      // completion coincident with consumption
      ticks(16, 11, 0, 1'b0, "coinc.a");
      ticks(15, 22, 0, 1'b0, "coinc.b");
      ticks(1, 22, 0, 1'b1, "coinc.last");
      cyc(1'b0, 0, 1'b0, 1'b1, "coinc.drain");

      // clear coincident with a tick
      ticks(7, 50, 0, 1'b1, "clr50");
      cyc(1'b1, 50, 1'b1, 1'b1, "clr.tick");
      ticks(16, 20, 1, 1'b1, "clr20");

      // async reset mid-block
      ticks(7, 50, 0, 1'b0, "rst50");
      do_reset_pulse("rst.mid");
      ticks(16, 20, 0, 1'b1, "rst20");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r24 = DATA_W'($urandom);
         case ($urandom_range(0, 5))
            0: s = 8388607;
            1: s = -8388608;
            2: s = longint'($signed(r24)) % 64;
            default: s = longint'($signed(r24));
         endcase
         cyc(($urandom_range(0, 2) != 0), s, ($urandom_range(0, 400) == 0),
             ($urandom_range(0, 3) == 0), "rand");
         if (i == 1500) do_reset_pulse("rand.rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_block_averager.md
Name: tick_block_averager

Overview:
- Sits directly downstream of the 100-cycle tick delay stage and consumes its delayed tick.
- On every delayed tick it captures one ADC sample and accumulates it.
- After 2^LOG2_N ticks it emits the block mean through a valid/ready output register, then starts the next block.
- Feeds the lock-in / readout logic, which may stall via ready_i.

Parameters:
- DATA_W, 24: width of the signed input sample and the signed average output.
- LOG2_N, 4: log2 of samples per block (N = 16 by default). Legal range 1..8.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- tick_i  in  1  one-cycle sample strobe (the delayed tick); sample_i is captured in the same cycle.
- sample_i  in  DATA_W  signed two's-complement sample, valid when tick_i=1.
- clear_i  in  1  synchronous clear of the block in progress, the output and the flags.
- avg_o  out  DATA_W  signed block average.
- valid_o  out  1  avg_o holds an unconsumed result.
- ready_i  in  1  consumer accepts avg_o when valid_o && ready_i.
- overrun_o  out  1  sticky: an unconsumed result was overwritten.
- fill_o  out  LOG2_N  number of samples accumulated in the current block.

Behaviour:
- Reset (reset_ni=0, asynchronous): acc=0, fill_o=0, avg_o=0, valid_o=0, overrun_o=0. Outputs stay at these values until the first clock edge after reset_ni rises.
- Accumulator: ACC_W = DATA_W+LOG2_N bits, signed. sample_i is sign-extended before addition. The accumulator cannot overflow for any N samples.
- The accumulator has two states:
  - ACCUM: waiting for or counting ticks.
  - DUMP: a conceptual one-cycle event, not a held state.
- tick_i=1 with fill_o < N-1: acc += sample_i; fill_o += 1.
- tick_i=1 with fill_o == N-1 (Nth sample):
  - On that edge, avg_o <= (acc + sample_i) >>> LOG2_N. This is an arithmetic shift, so results round toward minus infinity. Keep the low DATA_W bits, which is exact by construction.
  - On the same edge, valid_o <= 1, acc <= 0 and fill_o <= 0.
  - Latency: avg_o/valid_o are visible the cycle after the Nth tick.
- tick_i=0: acc and fill_o hold. Gaps of any length between ticks are legal.
- Output handshake:
  - valid_o && ready_i at an edge with no new result: valid_o <= 0; avg_o holds its stale value.
  - New result while valid_o=1 and ready_i=0: avg_o is overwritten with the new result, valid_o stays 1, overrun_o <= 1.
  - New result while valid_o=1 and ready_i=1 (same edge): the old value is consumed and the new one loaded. valid_o stays 1 and there is no overrun.
  - ready_i while valid_o=0: no effect.
- overrun_o stays high until clear_i or reset.
- clear_i=1 (priority over tick_i and ready_i):
  - acc <= 0, fill_o <= 0, valid_o <= 0, overrun_o <= 0; avg_o holds.
  - A tick in the same cycle is discarded.
- Back-to-back ticks every cycle are supported: N consecutive ticks produce one result. The next block's first sample may arrive on the cycle right after the Nth tick.
- Reset asserted mid-block: the partial block is discarded immediately and does not need a clock edge.

Test Plan:
- Defaults, ready_i=1, 16 ticks with sample_i=100, one tick every 3 cycles -> one cycle after the 16th tick: valid_o=1, avg_o=100, fill_o=0. valid_o=0 the following cycle.
- 15 ticks with sample_i=0 then one tick with sample_i=-1 -> avg_o=-1 (floor). 16 ticks of -3 -> avg_o=-3.
- 16 back-to-back ticks of +8388607, then 16 of -8388608, ready_i=1 -> avg_o=8388607, then avg_o=-8388608; no wraparound.
- ready_i=0, 32 ticks of value 5 then 32 of value 7 -> after the 32nd tick overrun_o=1 and avg_o=5. After the 64th tick avg_o=7 and valid_o=1. Raise ready_i -> valid_o=0 next cycle; overrun_o stays 1 until clear_i.
- Result completes while ready_i=1 and valid_o=1 from the previous block -> valid_o stays 1, avg_o updates, overrun_o=0.
- 7 ticks of 50, then clear_i coincident with a tick, then 16 ticks of 20 -> fill_o=0 after clear, avg_o=20. Repeat with reset_ni pulsed low mid-block -> all outputs 0 asynchronously; next full block averages correctly.
